// File: rtl/pipe_mul.sv
// rtl/pipe_mul.sv - fully pipelined integer multiplier with valid/ready stall, tag passthrough; optional PIPE_MUL_OVF_EN adds out_ovf
module pipe_mul #(
    parameter int WIDTH        = 32,
    parameter int LATENCY      = 11,
    parameter int SIGNED       = 0,
    parameter int FULL_PRODUCT = 0,
    parameter int TAG_W        = 4,
    localparam int OUT_W       = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef PIPE_MUL_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // The whole pipeline moves as one unit: it advances whenever the output
    // register is empty or is being drained this cycle.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operands and tag as seen by the final (multiplying) stage.
    logic             mul_valid;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [TAG_W-1:0] mul_tag;

    generate
        if (LATENCY == 1) begin : g_no_dly
            assign mul_valid = in_valid;
            assign mul_a     = in_a;
            assign mul_b     = in_b;
            assign mul_tag   = in_tag;
        end else begin : g_dly
            localparam int N = LATENCY - 1;
            logic [N-1:0]     v_q;
            logic [WIDTH-1:0] a_q [N];
            logic [WIDTH-1:0] b_q [N];
            logic [TAG_W-1:0] t_q [N];

            // Operand/tag delay line; bubbles travel as stages with v_q=0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                        t_q[i] <= '0;
                    end
                end else if (adv) begin
                    v_q[0] <= in_valid;
                    a_q[0] <= in_a;
                    b_q[0] <= in_b;
                    t_q[0] <= in_tag;
                    for (int i = 1; i < N; i++) begin
                        v_q[i] <= v_q[i-1];
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                        t_q[i] <= t_q[i-1];
                    end
                end
            end

            assign mul_valid = v_q[N-1];
            assign mul_a     = a_q[N-1];
            assign mul_b     = b_q[N-1];
            assign mul_tag   = t_q[N-1];
        end
    endgenerate

    // Operands extended to the output width; the low WIDTH bits of a product
    // do not depend on signedness, so the narrow case needs no extension.
    logic [OUT_W-1:0] ext_a;
    logic [OUT_W-1:0] ext_b;
    logic [OUT_W-1:0] prod;

    generate
        if (FULL_PRODUCT != 0) begin : g_wide
            logic sa;
            logic sb;
            assign sa    = (SIGNED != 0) ? mul_a[WIDTH-1] : 1'b0;
            assign sb    = (SIGNED != 0) ? mul_b[WIDTH-1] : 1'b0;
            assign ext_a = {{WIDTH{sa}}, mul_a};
            assign ext_b = {{WIDTH{sb}}, mul_b};
        end else begin : g_narrow
            assign ext_a = mul_a;
            assign ext_b = mul_b;
        end
    endgenerate

    assign prod = ext_a * ext_b;

`ifdef PIPE_MUL_OVF_EN
    logic ovf_d;

    generate
        if (FULL_PRODUCT != 0) begin : g_ovf_none
            assign ovf_d = 1'b0;
        end else begin : g_ovf_chk
            logic             fa_s;
            logic             fb_s;
            logic [2*WIDTH-1:0] full_a;
            logic [2*WIDTH-1:0] full_b;
            logic [2*WIDTH-1:0] full_p;
            logic             low_s;
            assign fa_s   = (SIGNED != 0) ? mul_a[WIDTH-1] : 1'b0;
            assign fb_s   = (SIGNED != 0) ? mul_b[WIDTH-1] : 1'b0;
            assign full_a = {{WIDTH{fa_s}}, mul_a};
            assign full_b = {{WIDTH{fb_s}}, mul_b};
            assign full_p = full_a * full_b;
            // Truncation is lossless exactly when re-extending the kept low
            // half reproduces the full product.
            assign low_s  = (SIGNED != 0) ? full_p[WIDTH-1] : 1'b0;
            assign ovf_d  = (full_p != {{WIDTH{low_s}}, full_p[WIDTH-1:0]});
        end
    endgenerate

    // Overflow flag registered alongside the product so it stalls with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (adv) begin
            out_ovf <= ovf_d;
        end
    end
`endif

    // Final stage: register the product, tag and valid; hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= mul_valid;
            out_data  <= prod;
            out_tag   <= mul_tag;
        end
    end

endmodule

// File: tb/tb_pipe_mul.sv
// tb/tb_pipe_mul.sv - self-checking bench for pipe_mul with queue-based reference model
module tb_pipe_mul;

    localparam int LAT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic [3:0]  in_tag    = '0;
    wire         in_ready;
    wire         out_valid;
    wire  [31:0] out_data;
    wire  [3:0]  out_tag;

    logic        s_valid = 1'b0;
    logic [7:0]  s_a     = '0;
    logic [7:0]  s_b     = '0;
    logic [3:0]  s_tag   = '0;
    wire         r1, r2, r3, r4;
    wire         v1, v2, v3, v4;
    wire  [7:0]  d1, d4;
    wire  [15:0] d2, d3;
    wire  [3:0]  t1, t2, t3, t4;

`ifdef PIPE_MUL_OVF_EN
    wire o0, o1, o2, o3, o4;
`endif

    pipe_mul u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef PIPE_MUL_OVF_EN
        , .out_ovf(o0)
`endif
    );

    pipe_mul #(.WIDTH(8), .LATENCY(3), .SIGNED(1), .FULL_PRODUCT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r1),
        .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .out_valid(v1),
        .out_ready(1'b1), .out_data(d1), .out_tag(t1)
`ifdef PIPE_MUL_OVF_EN
        , .out_ovf(o1)
`endif
    );

    pipe_mul #(.WIDTH(8), .LATENCY(3), .SIGNED(1), .FULL_PRODUCT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r2),
        .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .out_valid(v2),
        .out_ready(1'b1), .out_data(d2), .out_tag(t2)
`ifdef PIPE_MUL_OVF_EN
        , .out_ovf(o2)
`endif
    );

    pipe_mul #(.WIDTH(8), .LATENCY(3), .SIGNED(0), .FULL_PRODUCT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r3),
        .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .out_valid(v3),
        .out_ready(1'b1), .out_data(d3), .out_tag(t3)
`ifdef PIPE_MUL_OVF_EN
        , .out_ovf(o3)
`endif
    );

    pipe_mul #(.WIDTH(8), .LATENCY(1), .SIGNED(0), .FULL_PRODUCT(0)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r4),
        .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .out_valid(v4),
        .out_ready(1'b1), .out_data(d4), .out_tag(t4)
`ifdef PIPE_MUL_OVF_EN
        , .out_ovf(o4)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted op records how many advancing edges had
    // happened; it is presentable once LAT-1 further advancing edges passed.
    typedef struct {
        int          k;
        logic [31:0] d;
        logic [3:0]  t;
        logic        o;
    } ent_t;

    ent_t q[$];
    int   adv_edges = 0;
    int   got       = 0;

    function automatic logic model_valid();
        return (q.size() > 0) && (adv_edges - q[0].k >= LAT - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic   mv;
        logic [63:0] p;
        ent_t   e;
        if (!rst_n) begin
            q.delete();
            adv_edges = 0;
        end else begin
            mv = model_valid();
            if (mv && out_ready) begin
                void'(q.pop_front());
                got++;
            end
            if (!mv || out_ready) begin
                adv_edges++;
                if (in_valid) begin
                    p   = {32'd0, in_a} * {32'd0, in_b};
                    e.k = adv_edges;
                    e.d = p[31:0];
                    e.t = in_tag;
                    e.o = (p[63:32] != 32'd0);
                    q.push_back(e);
                end
            end
        end
    end

    // Every-cycle compare of the default instance against the model.
    always @(negedge clk) begin : compare
        logic mv;
        if (!rst_n) begin
            chk("reset_outputs", {out_valid, out_tag, out_data}, 64'd0);
        end else begin
            mv = model_valid();
            chk("out_valid", out_valid, mv);
            chk("in_ready", in_ready, !mv || out_ready);
            if (mv) begin
                chk("out_data", out_data, q[0].d);
                chk("out_tag", out_tag, q[0].t);
`ifdef PIPE_MUL_OVF_EN
                chk("out_ovf", o0, q[0].o);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic small_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] e4, input logic ov4,
                            input logic [7:0] e1, input logic ov1,
                            input logic [15:0] e2, input logic [15:0] e3);
        s_a     = a;
        s_b     = b;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("u4_valid", v4, 1'b1);
        chk("u4_data", d4, e4);
`ifdef PIPE_MUL_OVF_EN
        chk("u4_ovf", o4, ov4);
`endif
        step();
        step();
        chk("u1_valid", v1, 1'b1);
        chk("u1_data", d1, e1);
        chk("u2_data", d2, e2);
        chk("u3_data", d3, e3);
        chk("u23_valid", {v2, v3}, 2'b11);
`ifdef PIPE_MUL_OVF_EN
        chk("u1_ovf", o1, ov1);
        chk("u23_ovf", {o2, o3}, 2'b00);
`endif
        if (ov4 === 1'bx || ov1 === 1'bx) chk("ovf_arg", 1'b0, 1'b1);
    endtask

    int          n;
    int          g0;
    logic [31:0] obs[$];
    int          cyc[$];
    logic [31:0] d0;
    logic [3:0]  t0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("post_reset", {out_valid, out_tag, out_data}, 64'd0);

        // Single op 3*5 tag 2.
        in_a = 3; in_b = 5; in_tag = 2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        chk("single_latency", n, LAT - 1);
        chk("single_data", out_data, 15);
        chk("single_tag", out_tag, 2);
        step();
        chk("single_once", out_valid, 1'b0);
        repeat (3) step();

        // Stream of 20 with a one-cycle gap before op 10.
        g0 = got;
        for (int c = 0; c < 36; c++) begin
            if (c < 21 && c != 10) begin
                n = (c > 10) ? c - 1 : c;
                in_valid = 1'b1;
                in_a = n; in_b = n + 1; in_tag = 4'(n);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid) begin
                obs.push_back(out_data);
                cyc.push_back(c);
            end
        end
        in_valid = 1'b0;
        chk("stream_count", got - g0, 20);
        chk("stream_obs", obs.size(), 20);
        if (obs.size() == 20) begin
            chk("stream_5", obs[5], 30);
            chk("stream_19", obs[19], 380);
            chk("stream_gap", cyc[10] - cyc[9], 2);
            chk("stream_b2b", cyc[9] - cyc[8], 1);
        end

        // Fill, then stall for 5 cycles.
        for (int j = 0; j < 12; j++) begin
            in_valid = 1'b1; in_a = 100 + j; in_b = 7; in_tag = 4'(j);
            step();
        end
        out_ready = 1'b0;
        in_a = 200; in_b = 2; in_tag = 4'hc;
        d0 = out_data;
        t0 = out_tag;
        chk("stall_head_data", d0, 707);
        chk("stall_head_tag", t0, 1);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stall_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, d0);
            chk("stall_tag", out_tag, t0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (15) step();
        chk("stall_drained", q.size(), 0);

        // Reset with ops in flight, some already at the output.
        for (int j = 0; j < 14; j++) begin
            in_valid = 1'b1; in_a = j + 1; in_b = 3; in_tag = 4'(j);
            step();
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_valid", out_valid, 1'b0);
        chk("midreset_data", out_data, 0);
        chk("midreset_tag", out_tag, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 15; j++) begin
            step();
            chk("no_stale", out_valid, 1'b0);
        end

        // Narrow-width signedness / product-width / overflow cases.
        small_op(8'hfd, 8'h05, 8'hf1, 1'b1, 8'hf1, 1'b0, 16'hfff1, 16'h04f1);
        small_op(8'h10, 8'h10, 8'h00, 1'b1, 8'h00, 1'b1, 16'h0100, 16'h0100);
        small_op(8'h0f, 8'h11, 8'hff, 1'b0, 8'hff, 1'b1, 16'h00ff, 16'h00ff);
        small_op(8'h80, 8'hff, 8'h80, 1'b1, 8'h80, 1'b1, 16'h0080, 16'h7f80);
        step();
        chk("small_idle", {v1, v2, v3, v4}, 4'b0000);
        chk("small_ready", {r1, r2, r3, r4}, 4'b1111);
        chk("small_tags", {t1, t2, t3, t4}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
